// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU definitions: FSM state encodings and nibble width.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_sub_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_sub_if
//  Brief    : Operand/result valid-ready bundle for the serial subtractor.
//             Compare outputs lt/ltu/eq exist only when SUB_CMP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface nibble_serial_sub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
`ifdef SUB_CMP_EN
  logic             lt;
  logic             ltu;
  logic             eq;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero, lt, ltu, eq
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero, lt, ltu, eq
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
`endif

endinterface
`default_nettype wire

// File: rtl/nibble_sub_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_sub_4bit
//  Brief    : Combinational 4-bit carry-lookahead stage computing a + ~b + cin.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_sub_4bit
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  assign p = a ^ ~b;
  assign g = a & ~b;

  // Flattened lookahead equations: every carry depends only on p, g and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_sub
//  Brief    : Multi-cycle subtractor diff = a - b - bin, one nibble per clock,
//             LSB first. Optional macro SUB_CMP_EN adds lt/ltu/eq outputs.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  nibble_serial_sub_if.slave bus
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int K_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_sub: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             c_q, c_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
`ifdef SUB_CMP_EN
  logic             lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;
`endif

  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             c_out;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k_q == K_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  nibble_sub_4bit u_nib (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c_q),
    .s    (s_nib),
    .cout (c_out)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef SUB_CMP_EN
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    eq_d    = eq_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = ~bus.bin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (k_q == K_W'(i)) diff_d[i*NIB_W +: NIB_W] = s_nib;
        end
        c_d = c_out;
        k_d = k_q + 1'b1;
        // Flags are taken from the fully assembled result on the last nibble.
        if (k_q == K_W'(NIB - 1)) begin
          state_d = DONE;
          bout_d  = ~c_out;
          ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
          zero_d  = (diff_d == '0);
`ifdef SUB_CMP_EN
          lt_d    = diff_d[MSB] ^ ovf_d;
          ltu_d   = bout_d;
          eq_d    = zero_d;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      k_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SUB_CMP_EN
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      eq_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      k_q         <= k_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SUB_CMP_EN
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
      eq_q        <= eq_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
`ifdef SUB_CMP_EN
  assign bus.lt        = lt_q;
  assign bus.ltu       = ltu_q;
  assign bus.eq        = eq_q;
`endif

endmodule
`default_nettype wire
